division_seq: RTL and testbench

Multi-cycle restoring divider, parametrised in width, with a signed/unsigned mode and a valid/ready handshake on both sides. It returns quotient, remainder and a 4-bit status word. It replaces the single-cycle combinational divider in the ALU datapath wherever timing cannot close at full operand width. One division is in flight at a time; the block is iterative, not pipelined.

---
 rtl/division_seq.sv | 117 +++++++++++
 tb/tb_division_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/division_seq.sv
// Iterative restoring divider with signed/unsigned mode and valid/ready handshakes.
// One division in flight; a normal division takes N CALC steps plus one FIX cycle.
module division_seq #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_signed,
    input  logic [N-1:0] i_arg_A,
    input  logic [N-1:0] i_arg_B,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_div,
    output logic [N-1:0] o_rem,
    output logic [3:0]   o_status
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [N-1:0]  remainder;
    logic [CW-1:0] count;
    logic          neg_quo;
    logic          neg_rem;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [N-1:0]  quo_fix;
    logic [N-1:0]  rem_fix;
    logic          min_over_neg_one;

    // The dividend register doubles as the quotient: each step shifts one
    // dividend bit out into the partial remainder and one quotient bit in.
    always_comb begin
        shifted          = {remainder, dividend[N-1]};
        diff             = shifted - {1'b0, divisor};
        quo_fix          = neg_quo ? -dividend : dividend;
        rem_fix          = neg_rem ? -remainder : remainder;
        min_over_neg_one = i_signed && (i_arg_A == {1'b1, {(N-1){1'b0}}}) && (i_arg_B == '1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            dividend  <= '0;
            divisor   <= '0;
            remainder <= '0;
            count     <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_div     <= '0;
            o_rem     <= '0;
            o_status  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_ready <= 1'b0;
                        if (i_arg_B == '0) begin
                            o_div    <= '0;
                            o_rem    <= '0;
                            o_status <= 4'b0001;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else if (min_over_neg_one) begin
                            o_div    <= '0;
                            o_rem    <= '0;
                            o_status <= 4'b1000;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // The magnitude of -2^(N-1) is still representable as unsigned N bits.
                            dividend  <= (i_signed && i_arg_A[N-1]) ? -i_arg_A : i_arg_A;
                            divisor   <= (i_signed && i_arg_B[N-1]) ? -i_arg_B : i_arg_B;
                            remainder <= '0;
                            count     <= CW'(N);
                            neg_quo   <= i_signed && (i_arg_A[N-1] ^ i_arg_B[N-1]);
                            neg_rem   <= i_signed && i_arg_A[N-1];
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    remainder <= diff[N] ? shifted[N-1:0] : diff[N-1:0];
                    dividend  <= {dividend[N-2:0], ~diff[N]};
                    count     <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    o_div    <= quo_fix;
                    o_rem    <= rem_fix;
                    o_status <= {1'b0, &quo_fix, (~^quo_fix) & (|quo_fix), 1'b0};
                    o_valid  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_division_seq.sv
// Directed self-checking bench for division_seq: expected results are queued
// when a request is accepted and compared when the divider presents o_valid.
module tb_division_seq;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] quo;
        logic [N-1:0] rem;
        logic [3:0]   status;
        int           latency;
    } expect_t;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_signed;
    logic [N-1:0] i_arg_A;
    logic [N-1:0] i_arg_B;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_div;
    logic [N-1:0] o_rem;
    logic [3:0]   o_status;

    expect_t scoreboard[$];
    int      tests_run    = 0;
    int      tests_failed = 0;

    division_seq #(.N(N)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_signed (i_signed),
        .i_arg_A  (i_arg_A),
        .i_arg_B  (i_arg_B),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_div    (o_div),
        .o_rem    (o_rem),
        .o_status (o_status)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic recordTimeout(input string tag);
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Drive one request, wait for the accept edge, then queue its expected result.
    // Operands are scrambled straight after acceptance; they must not matter.
    task automatic applyStimulus(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] quo, input logic [N-1:0] rem,
                                 input logic [3:0] status, input int latency);
        expect_t e;
        int      waited = 0;
        i_signed = sgn;
        i_arg_A  = a;
        i_arg_B  = b;
        i_valid  = 1'b1;
        while (!o_ready && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) begin
            i_valid = 1'b0;
            recordTimeout("accept_timeout");
        end else begin
            @(posedge i_clk);
            #1;
            i_valid  = 1'b0;
            i_arg_A  = ~a;
            i_arg_B  = '0;
            i_signed = ~sgn;
            e.quo     = quo;
            e.rem     = rem;
            e.status  = status;
            e.latency = latency;
            scoreboard.push_back(e);
        end
    endtask

    // Latency counts cycles after the accept cycle: 1 means the very next cycle.
    task automatic waitResult(output int latency);
        latency = 1;
        @(negedge i_clk);
        while (!o_valid && latency < 60) begin
            @(negedge i_clk);
            latency++;
        end
        if (!o_valid) recordTimeout("result_timeout");
    endtask

    task automatic checkOutput(input string tag, input int latency);
        expect_t e;
        if (scoreboard.size() == 0) begin
            recordTimeout({tag, "_scoreboard_empty"});
        end else begin
            e = scoreboard.pop_front();
            checkEq({tag, "_valid"},   32'(o_valid),  32'd1);
            checkEq({tag, "_ready"},   32'(o_ready),  32'd0);
            checkEq({tag, "_div"},     32'(o_div),    32'(e.quo));
            checkEq({tag, "_rem"},     32'(o_rem),    32'(e.rem));
            checkEq({tag, "_status"},  32'(o_status), 32'(e.status));
            checkEq({tag, "_latency"}, 32'(latency),  32'(e.latency));
        end
    endtask

    task automatic checkRelease(input string tag);
        @(negedge i_clk);
        checkEq({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        checkEq({tag, "_ready_rise"}, 32'(o_ready), 32'd1);
    endtask

    task automatic runOne(input string tag, input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] quo, input logic [N-1:0] rem,
                          input logic [3:0] status, input int latency);
        int lat;
        applyStimulus(sgn, a, b, quo, rem, status, latency);
        waitResult(lat);
        checkOutput(tag, lat);
        checkRelease(tag);
    endtask

    initial begin
        int lat;
        int seen;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_signed = 1'b0;
        i_arg_A  = '0;
        i_arg_B  = '0;
        i_ready  = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        checkEq("reset_ready",  32'(o_ready),  32'd1);
        checkEq("reset_valid",  32'(o_valid),  32'd0);
        checkEq("reset_div",    32'(o_div),    32'd0);
        checkEq("reset_rem",    32'(o_rem),    32'd0);
        checkEq("reset_status", 32'(o_status), 32'd0);

        runOne("s_100_7",      1'b1, 8'd100, 8'd7,   8'd14,  8'd2,  4'b0000, N + 2);
        runOne("s_m100_7",     1'b1, 8'h9C,  8'd7,   8'hF2,  8'hFE, 4'b0000, N + 2);
        runOne("s_100_m7",     1'b1, 8'd100, 8'hF9,  8'hF2,  8'd2,  4'b0000, N + 2);
        runOne("s_7_0",        1'b1, 8'd7,   8'd0,   8'd0,   8'd0,  4'b0001, 1);
        runOne("u_7_0",        1'b0, 8'd7,   8'd0,   8'd0,   8'd0,  4'b0001, 1);
        runOne("s_min_m1",     1'b1, 8'h80,  8'hFF,  8'd0,   8'd0,  4'b1000, 1);
        runOne("u_80_ff",      1'b0, 8'h80,  8'hFF,  8'd0,   8'h80, 4'b0000, N + 2);
        runOne("u_ff_1",       1'b0, 8'hFF,  8'd1,   8'hFF,  8'd0,  4'b0110, N + 2);
        runOne("u_12_4",       1'b0, 8'd12,  8'd4,   8'd3,   8'd0,  4'b0010, N + 2);
        runOne("u_200_7",      1'b0, 8'd200, 8'd7,   8'h1C,  8'd4,  4'b0000, N + 2);

        // Backpressure: result must hold and new requests must be ignored.
        i_ready = 1'b0;
        applyStimulus(1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 4'b0000, N + 2);
        waitResult(lat);
        checkOutput("bp_first", lat);
        i_signed = 1'b0;
        i_arg_A  = 8'd3;
        i_arg_B  = 8'd1;
        i_valid  = 1'b1;
        repeat (5) begin
            @(negedge i_clk);
            checkEq("bp_hold_valid",  32'(o_valid),  32'd1);
            checkEq("bp_hold_ready",  32'(o_ready),  32'd0);
            checkEq("bp_hold_div",    32'(o_div),    32'h0E);
            checkEq("bp_hold_rem",    32'(o_rem),    32'hFE);
            checkEq("bp_hold_status", 32'(o_status), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        checkRelease("bp");
        @(negedge i_clk);
        checkEq("bp_idle_ready", 32'(o_ready), 32'd1);
        checkEq("bp_idle_valid", 32'(o_valid), 32'd0);

        // Reset landing on the fourth CALC iteration.
        applyStimulus(1'b1, 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, N + 2);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        void'(scoreboard.pop_front());
        checkEq("rst_mid_valid",  32'(o_valid),  32'd0);
        checkEq("rst_mid_ready",  32'(o_ready),  32'd1);
        checkEq("rst_mid_div",    32'(o_div),    32'd0);
        checkEq("rst_mid_rem",    32'(o_rem),    32'd0);
        checkEq("rst_mid_status", 32'(o_status), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_valid) seen = 1;
        end
        checkEq("rst_no_partial", 32'(seen), 32'd0);

        runOne("s_9_3", 1'b1, 8'd9, 8'd3, 8'd3, 8'd0, 4'b0010, N + 2);

        checkEq("scoreboard_drained", 32'(scoreboard.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
